// File: rtl/core_pkg.sv
// core_pkg: shared PC-unit types and the default reset vector
package core_pkg;
  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_HOLD} pc_mode_t;
  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: controller/fetch-side bundle of the PC unit; history port exists only with PC_HISTORY_EN
interface pc_unit_if import core_pkg::*; #(
  parameter int XLEN = 32
`ifdef PC_HISTORY_EN
  , parameter int HIST_DEPTH = 4
`endif
);
  logic            advance;
  logic            fetch_ready;
  pc_mode_t        mode;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] base;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            halt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic            pc_valid;
  logic            misaligned;
  logic            halted;
`ifdef PC_HISTORY_EN
  logic [$clog2(HIST_DEPTH)-1:0] hist_idx;
  logic [XLEN-1:0]               hist_pc;
  logic [$clog2(HIST_DEPTH):0]   hist_count;
`endif
  modport master (
    output advance, fetch_ready, mode, imm, base, trap, trap_vec, halt,
`ifdef PC_HISTORY_EN
    output hist_idx,
    input  hist_pc, hist_count,
`endif
    input  pc, pc_seq, pc_valid, misaligned, halted
  );
  modport slave (
    input  advance, fetch_ready, mode, imm, base, trap, trap_vec, halt,
`ifdef PC_HISTORY_EN
    input  hist_idx,
    output hist_pc, hist_count,
`endif
    output pc, pc_seq, pc_valid, misaligned, halted
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC target mux with alignment flag
module pc_next_sel import core_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int INC        = 4,
  parameter int ALIGN_BITS = 2
)(
  input  pc_mode_t        i_mode,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_base,
  output logic [XLEN-1:0] o_target,
  output logic            o_misalign_flag
);
  logic [XLEN-1:0] w_jump;
  assign w_jump = i_base + i_imm;
  // pick the target for the requested mode; JUMP drops bit 0 like JALR
  always_comb begin
    o_target = i_mode == PC_SEQ    ? i_pc + XLEN'(INC) :
               i_mode == PC_BRANCH ? i_pc + i_imm :
               i_mode == PC_JUMP   ? {w_jump[XLEN-1:1], 1'b0} : i_pc;
    o_misalign_flag = |o_target[ALIGN_BITS-1:0];
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: handshake-driven program counter with trap/halt FSM; PC_HISTORY_EN adds a PC history buffer
module pc_unit import core_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              HIST_DEPTH   = 4
)(
  input logic      clk,
  input logic      reset,
  pc_unit_if.slave bus
);
  if ((HIST_DEPTH & (HIST_DEPTH - 1)) != 0 || HIST_DEPTH < 2) begin : g_bad_depth
    $error("HIST_DEPTH must be a power of two >= 2");
  end
  pc_state_t       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt, w_target;
  logic            r_misaligned, w_mis_nxt, w_misalign, w_upd, w_live;
  pc_next_sel #(.XLEN(XLEN), .INC(INC), .ALIGN_BITS(ALIGN_BITS)) u_sel (
    .i_mode          (bus.mode),
    .i_pc            (r_pc),
    .i_imm           (bus.imm),
    .i_base          (bus.base),
    .o_target        (w_target),
    .o_misalign_flag (w_misalign)
  );
  assign w_upd  = r_state == RUN && bus.advance && bus.fetch_ready;
  assign w_live = r_state == RUN && !bus.halt;
  // next state: halt beats trap, trap beats a handshake update, misaligned updates are dropped
  always_comb begin
    w_state_nxt = r_state == BOOT ? RUN : (r_state == RUN && bus.halt) ? HALT : r_state;
    w_pc_nxt    = !w_live ? r_pc : bus.trap ? bus.trap_vec : (w_upd && !w_misalign) ? w_target : r_pc;
    w_mis_nxt   = w_live && !bus.trap && w_upd && w_misalign;
  end
  // state, pc and misalignment pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_misaligned <= w_mis_nxt;
    end
  end
  assign bus.pc         = r_pc;
  assign bus.pc_seq     = r_pc + XLEN'(INC);
  assign bus.pc_valid   = r_state == RUN;
  assign bus.misaligned = r_misaligned;
  assign bus.halted     = r_state == HALT;
`ifdef PC_HISTORY_EN
  localparam int HW = $clog2(HIST_DEPTH);
  logic [XLEN-1:0] r_hist [HIST_DEPTH];
  logic [HW-1:0]   r_wptr;
  logic [HW:0]     r_hcount;
  logic            w_hist_we;
  assign w_hist_we = w_live && (bus.trap || (w_upd && !w_misalign));
  // record the outgoing pc on every accepted update or trap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_hcount <= '0;
    end else if (w_hist_we) begin
      r_hist[r_wptr] <= r_pc;
      r_wptr         <= r_wptr + HW'(1);
      r_hcount       <= r_hcount == (HW+1)'(HIST_DEPTH) ? r_hcount : r_hcount + (HW+1)'(1);
    end
  end
  assign bus.hist_pc    = r_hist[r_wptr - HW'(1) - bus.hist_idx];
  assign bus.hist_count = r_hcount;
`endif
endmodule
